// File: rtl/updown_counter_mod_pkg.sv
// rtl/updown_counter_mod_pkg.sv - direction constants and modulus helpers for the up/down counter
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic int max_count(input int modulus);
        return modulus - 1;
    endfunction

    // Modulus must leave at least two states and fit in the register.
    function automatic bit legal_modulus(input int width, input int modulus);
        return (modulus >= 2) && (longint'(modulus) <= (longint'(1) << width));
    endfunction

endpackage

// File: rtl/updown_counter_mod_if.sv
// rtl/updown_counter_mod_if.sv - control and status bundle of the up/down counter
interface updown_counter_mod_if #(
    parameter int WIDTH = 5
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;

    modport master (
        output en, up, load, load_val,
        input  q, tc, wrap
    );

    modport slave (
        input  en, up, load, load_val,
        output q, tc, wrap
    );
endinterface

// File: rtl/updown_counter_mod_next_state.sv
// rtl/updown_counter_mod_next_state.sv - next count, wrap flag and terminal count (combinational)
module counter_next_state
    import counter_pkg::*;
#(
    parameter int WIDTH   = 5,
    parameter int MODULUS = 32
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q_next,
    output logic             wrap_next,
    output logic             tc
);

    // One extra bit keeps q+1 exact when MODULUS is a full power of two.
    localparam logic [WIDTH:0] MAX_Q = (WIDTH+1)'(max_count(MODULUS));

    logic [WIDTH:0] q_ext;
    logic [WIDTH:0] lv_ext;
    logic [WIDTH:0] nxt;
    logic           at_max;
    logic           at_zero;

    assign q_ext   = {1'b0, q};
    assign lv_ext  = {1'b0, load_val};
    assign at_max  = (q_ext == MAX_Q);
    assign at_zero = (q_ext == '0);
    assign tc      = en & ((up == DIR_UP) ? at_max : at_zero);

    always_comb begin
        nxt       = q_ext;
        wrap_next = 1'b0;
        if (load) begin
            nxt = (lv_ext > MAX_Q) ? MAX_Q : lv_ext;
        end else if (en) begin
            if (up == DIR_UP) begin
                if (at_max) begin
`ifdef UPDOWN_COUNTER_SAT_EN
                    nxt = MAX_Q;
`else
                    nxt       = '0;
                    wrap_next = 1'b1;
`endif
                end else begin
                    nxt = q_ext + 1'b1;
                end
            end else begin
                if (at_zero) begin
`ifdef UPDOWN_COUNTER_SAT_EN
                    nxt = '0;
`else
                    nxt       = MAX_Q;
                    wrap_next = 1'b1;
`endif
                end else begin
                    nxt = q_ext - 1'b1;
                end
            end
        end
    end

    // nxt never exceeds MAX_Q, so its top bit is always zero.
    logic unused_nxt_msb;
    assign unused_nxt_msb = nxt[WIDTH];
    assign q_next         = nxt[WIDTH-1:0];

endmodule

// File: rtl/updown_counter_mod.sv
// rtl/updown_counter_mod.sv - synchronous up/down modulo-N counter; UPDOWN_COUNTER_SAT_EN selects saturation
module updown_counter_mod
    import counter_pkg::*;
#(
    parameter int WIDTH   = 5,
    parameter int MODULUS = 32
) (
    input  logic               clk,
    input  logic               clear,
    updown_counter_mod_if.slave bus
);

    if (!legal_modulus(WIDTH, MODULUS)) begin : g_bad_modulus
        $error("updown_counter_mod: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next;
    logic             wrap_next;

    counter_next_state #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .q         (q_r),
        .up        (bus.up),
        .en        (bus.en),
        .load      (bus.load),
        .load_val  (bus.load_val),
        .q_next    (q_next),
        .wrap_next (wrap_next),
        .tc        (bus.tc)
    );

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            q_r <= '0;
        end else begin
            q_r <= q_next;
        end
    end

`ifdef UPDOWN_COUNTER_SAT_EN
    logic unused_wrap_next;
    assign unused_wrap_next = wrap_next;
    assign bus.wrap         = 1'b0;
`else
    logic wrap_r;

    // Clear drops a pending wrap pulse immediately.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            wrap_r <= 1'b0;
        end else begin
            wrap_r <= wrap_next;
        end
    end

    assign bus.wrap = wrap_r;
`endif

    assign bus.q = q_r;

endmodule

// File: tb/tb_updown_counter_mod.sv
// tb/tb_updown_counter_mod.sv - scoreboard bench for updown_counter_mod
module tb_updown_counter_mod;

`ifdef UPDOWN_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        int    d;
        string tag;
        int    q;
        bit    w;
    } exp_t;

    logic       clk;
    logic [3:0] clr;
    int         n_checks;
    int         n_err;
    exp_t       sb[$];
    int         mq[5];
    int         mmod[5];

    logic [4:0] obs_q[5];
    logic       obs_tc[5];
    logic       obs_wrap[5];

    updown_counter_mod_if #(.WIDTH(5)) if0 ();
    updown_counter_mod_if #(.WIDTH(4)) if1 ();
    updown_counter_mod_if #(.WIDTH(4)) if2 ();
    updown_counter_mod_if #(.WIDTH(4)) if3 ();
    updown_counter_mod_if #(.WIDTH(4)) if4 ();

    updown_counter_mod #(.WIDTH(5), .MODULUS(32)) u_a  (.clk(clk), .clear(clr[0]), .bus(if0));
    updown_counter_mod #(.WIDTH(4), .MODULUS(10)) u_b  (.clk(clk), .clear(clr[1]), .bus(if1));
    updown_counter_mod #(.WIDTH(4), .MODULUS(16)) u_c  (.clk(clk), .clear(clr[2]), .bus(if2));
    updown_counter_mod #(.WIDTH(4), .MODULUS(10)) u_c0 (.clk(clk), .clear(clr[3]), .bus(if3));
    updown_counter_mod #(.WIDTH(4), .MODULUS(10)) u_c1 (.clk(clk), .clear(clr[3]), .bus(if4));

    assign if4.en = if3.tc;

    assign obs_q[0] = if0.q;
    assign obs_q[1] = {1'b0, if1.q};
    assign obs_q[2] = {1'b0, if2.q};
    assign obs_q[3] = {1'b0, if3.q};
    assign obs_q[4] = {1'b0, if4.q};
    assign obs_tc[0] = if0.tc;
    assign obs_tc[1] = if1.tc;
    assign obs_tc[2] = if2.tc;
    assign obs_tc[3] = if3.tc;
    assign obs_tc[4] = if4.tc;
    assign obs_wrap[0] = if0.wrap;
    assign obs_wrap[1] = if1.wrap;
    assign obs_wrap[2] = if2.wrap;
    assign obs_wrap[3] = if3.wrap;
    assign obs_wrap[4] = if4.wrap;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input bit en, input bit up, input bit ld, input int lv);
        case (d)
            0: begin if0.en = en; if0.up = up; if0.load = ld; if0.load_val = 5'(lv); end
            1: begin if1.en = en; if1.up = up; if1.load = ld; if1.load_val = 4'(lv); end
            2: begin if2.en = en; if2.up = up; if2.load = ld; if2.load_val = 4'(lv); end
            3: begin if3.en = en; if3.up = up; if3.load = ld; if3.load_val = 4'(lv); end
            default: begin if4.up = up; if4.load = ld; if4.load_val = 4'(lv); end
        endcase
    endtask

    function automatic bit mtc(input int d, input bit en, input bit up);
        return en && (up ? (mq[d] == mmod[d] - 1) : (mq[d] == 0));
    endfunction

    // Reference behaviour: load clamps, modulo wrap or saturate at the limits.
    task automatic model(input int d, input bit en, input bit up, input bit ld, input int lv,
                         output int nq, output bit w);
        int m;
        m  = mmod[d];
        nq = mq[d];
        w  = 1'b0;
        if (ld) begin
            nq = (lv >= m) ? m - 1 : lv;
        end else if (en) begin
            if (up) begin
                if (mq[d] == m - 1) begin
                    nq = SAT ? m - 1 : 0;
                    w  = !SAT;
                end else begin
                    nq = mq[d] + 1;
                end
            end else begin
                if (mq[d] == 0) begin
                    nq = SAT ? 0 : m - 1;
                    w  = !SAT;
                end else begin
                    nq = mq[d] - 1;
                end
            end
        end
        mq[d] = nq;
    endtask

    task automatic step(input int d, input bit en, input bit up, input bit ld, input int lv,
                        input string tag);
        int   nq;
        bit   w;
        exp_t e;
        drive(d, en, up, ld, lv);
        #1;
        chk({tag, "_tc"}, 32'(obs_tc[d]), 32'(mtc(d, en, up)));
        model(d, en, up, ld, lv, nq, w);
        sb.push_back('{d, tag, nq, w});
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        chk({e.tag, "_q"}, 32'(obs_q[e.d]), 32'(e.q));
        chk({e.tag, "_wrap"}, 32'(obs_wrap[e.d]), 32'(e.w));
        drive(d, 1'b0, up, 1'b0, lv);
    endtask

    initial begin
        int   nq0;
        int   nq1;
        bit   w0;
        bit   w1;
        bit   t0;
        int   wraps_obs;
        int   wraps_exp;
        exp_t e0;
        exp_t e1;

        n_checks  = 0;
        n_err     = 0;
        wraps_obs = 0;
        wraps_exp = 0;
        mmod      = '{32, 10, 16, 10, 10};
        mq        = '{0, 0, 0, 0, 0};
        clr       = 4'hF;
        for (int d = 0; d < 5; d++) drive(d, 1'b0, 1'b1, 1'b0, 0);
        if0.en = 1'b1;
        if0.up = 1'b0;
        #2;
        for (int d = 0; d < 5; d++) begin
            chk($sformatf("reset_q%0d", d), 32'(obs_q[d]), 32'd0);
            chk($sformatf("reset_wrap%0d", d), 32'(obs_wrap[d]), 32'd0);
        end
        chk("reset_tc_down_en", 32'(obs_tc[0]), 32'd1);
        chk("reset_tc_idle", 32'(obs_tc[1]), 32'd0);
        @(negedge clk);
        clr = 4'h0;
        if0.en = 1'b0;

        // Asynchronous clear in the middle of an up count.
        step(0, 1'b1, 1'b1, 1'b1, 12, "a_load12");
        step(0, 1'b1, 1'b1, 1'b0, 0, "a_up13");
        if0.en = 1'b1;
        if0.up = 1'b1;
        clr[0] = 1'b1;
        mq[0]  = 0;
        #1;
        chk("a_clear_q", 32'(obs_q[0]), 32'd0);
        chk("a_clear_wrap", 32'(obs_wrap[0]), 32'd0);
        chk("a_clear_tc_up", 32'(obs_tc[0]), 32'd0);
        if0.up = 1'b0;
        #1;
        chk("a_clear_tc_down", 32'(obs_tc[0]), 32'd1);
        if0.up = 1'b1;
        #1;
        clr[0] = 1'b0;
        step(0, 1'b1, 1'b1, 1'b0, 0, "a_resume1");
        step(0, 1'b1, 1'b1, 1'b0, 0, "a_resume2");
        step(0, 1'b1, 1'b1, 1'b0, 0, "a_resume3");

        // Clear between edges drops a pending wrap pulse.
        step(0, 1'b0, 1'b1, 1'b1, 31, "a_load31");
        step(0, 1'b1, 1'b1, 1'b0, 0, "a_wrap31");
        clr[0] = 1'b1;
        mq[0]  = 0;
        #1;
        chk("a_drop_wrap", 32'(obs_wrap[0]), 32'd0);
        chk("a_drop_q", 32'(obs_q[0]), 32'd0);
        #1;
        clr[0] = 1'b0;
        @(negedge clk);

        // Modulus 10: up wrap, down wrap, load priority and clamp.
        step(1, 1'b0, 1'b1, 1'b1, 8, "b_load8");
        step(1, 1'b1, 1'b1, 1'b0, 0, "b_up9");
        step(1, 1'b1, 1'b1, 1'b0, 0, "b_up_wrap");
        step(1, 1'b1, 1'b1, 1'b0, 0, "b_up1");
        step(1, 1'b0, 1'b0, 1'b1, 1, "b_load1");
        step(1, 1'b1, 1'b0, 1'b0, 0, "b_dn0");
        step(1, 1'b1, 1'b0, 1'b0, 0, "b_dn_wrap");
        step(1, 1'b1, 1'b0, 1'b0, 0, "b_dn8");
        step(1, 1'b1, 1'b1, 1'b0, 0, "b_dir_flip");
        step(1, 1'b1, 1'b1, 1'b1, 12, "b_load_clamp");
        step(1, 1'b0, 1'b0, 1'b1, 4, "b_load4");
        step(1, 1'b0, 1'b1, 1'b0, 0, "b_hold_a");
        step(1, 1'b0, 1'b0, 1'b0, 0, "b_hold_b");

        // Full power-of-two range.
        step(2, 1'b0, 1'b1, 1'b1, 15, "c_load15");
        step(2, 1'b1, 1'b1, 1'b0, 0, "c_up_full");
        step(2, 1'b1, 1'b1, 1'b0, 0, "c_up_after");

        // Two-stage BCD cascade for 100 clocks.
        drive(3, 1'b1, 1'b1, 1'b0, 0);
        drive(4, 1'b0, 1'b1, 1'b0, 0);
        for (int k = 1; k <= 100; k++) begin
            #1;
            t0 = mtc(3, 1'b1, 1'b1);
            chk($sformatf("casc_tc_%0d", k), 32'(obs_tc[3]), 32'(t0));
            model(3, 1'b1, 1'b1, 1'b0, 0, nq0, w0);
            model(4, t0, 1'b1, 1'b0, 0, nq1, w1);
            sb.push_back('{3, "casc0", nq0, w0});
            sb.push_back('{4, "casc1", nq1, w1});
            if (w1) wraps_exp++;
            @(posedge clk);
            @(negedge clk);
            e0 = sb.pop_front();
            e1 = sb.pop_front();
            chk($sformatf("casc_bcd_%0d", k), 32'({obs_q[e1.d], obs_q[e0.d]}),
                32'({5'(e1.q), 5'(e0.q)}));
            if (obs_wrap[4] === 1'b1) wraps_obs++;
        end
        drive(3, 1'b0, 1'b1, 1'b0, 0);
        chk("casc_stage1_final", 32'(obs_q[4]), 32'(mq[4]));
        chk("casc_stage1_wraps", 32'(wraps_obs), 32'(wraps_exp));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/updown_counter_mod.md
Name: updown_counter_mod

Overview:
- Synchronous, parametrised up/down modulo-N counter. Successor to the fixed 5-bit ripple JK down-counter.
- All bits change on one clock edge, so there is no ripple skew.
- Adds selectable direction, arbitrary modulus, parallel load, count enable, terminal-count output and a registered wrap pulse.
- Used as the general timing/sequence counter in later lab datapaths and as a clock-enable divider.

Parameters:
- WIDTH, 5, counter register width in bits.
- MODULUS, 32, count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH; elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock.
- clear  input  1  asynchronous, active-high reset.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value loaded when load=1.
- q  output  WIDTH  current count (registered).
- tc  output  1  terminal count (combinational).
- wrap  output  1  one-cycle pulse, registered.

Behaviour:
- Reset: clear=1 forces q=0 and wrap=0 immediately, without waiting for clk; both hold while clear=1.
  - tc is then 1 if en=1 and up=0, otherwise 0.
- Priority at each rising clk edge: clear > load > en > hold.
- Load:
  - load=1 sets q=load_val on the next edge, regardless of en or up.
  - If load_val >= MODULUS, q=MODULUS-1 (clamp).
  - A load forces wrap=0 on that edge.
- Count up (en=1, up=1, load=0):
  - q < MODULUS-1 gives q+1.
  - q == MODULUS-1 gives q=0 and wrap=1 on the same edge.
- Count down (en=1, up=0, load=0):
  - q > 0 gives q-1.
  - q == 0 gives q=MODULUS-1 and wrap=1.
- Hold (en=0, load=0): q unchanged; wrap=0.
- wrap:
  - Asserted exactly one cycle, registered, following the edge on which the wrap-around occurred.
  - Cleared on every edge that is not a wrap.
- tc = en & (up ? q==MODULUS-1 : q==0).
  - Combinational, so tc=1 means "this edge will wrap".
  - Intended for cascading: drive the next stage's en.
- Latency: one clk from en/load to q.
- Direction change mid-count takes effect on the next edge; there is no dead cycle.
- Arithmetic:
  - All comparisons are unsigned, WIDTH bits.
  - The next-state value is computed in WIDTH+1 bits so q+1 never overflows silently when MODULUS = 2**WIDTH.
- Asynchronous clear released mid-cycle: the counter resumes from 0 on the first subsequent edge.
- clear asserted between edges: q goes to 0 at once, and any pending wrap is dropped.

Optional Feature:
- Macro: UPDOWN_COUNTER_SAT_EN.
- Defined (saturating mode):
  - Up at MODULUS-1 holds MODULUS-1.
  - Down at 0 holds 0.
  - wrap is never asserted and is tied to 0.
  - tc keeps the same definition and indicates "at limit".
- Undefined: modulo wrap-around behaviour exactly as described above.

Decomposition:
- Package counter_pkg holds:
  - direction constants DIR_UP=1'b1 and DIR_DOWN=1'b0.
  - a function max_count(MODULUS) returning MODULUS-1.
  - a function legal_modulus(WIDTH, MODULUS) used by the elaboration check.
- One natural combinational sub-module: counter_next_state.
  - Inputs: q, up, en, load, load_val.
  - Outputs: next q, wrap_next, tc.
  - Keeps the top block to the register, async clear and wrap flop.

Test Plan:
- Reset mid-count: WIDTH=5, MODULUS=32, counting up at q=13; pulse clear between edges -> q=0 immediately, wrap=0, and counting resumes 1,2,3 after release.
- Up wrap: MODULUS=10, up=1, en=1 from q=8 -> q sequence 9,0,1; tc=1 while q=9; wrap=1 only in the cycle after q becomes 0.
- Down wrap: MODULUS=10, up=0 from q=1 -> q sequence 0,9,8; tc=1 while q=0; one wrap pulse.
- Load priority and clamp: MODULUS=10, en=1, load=1, load_val=12 -> q=9, wrap=0; then load_val=4 with en=0 -> q=4; then hold with en=0 -> q stays 4.
- Full-range power of two: WIDTH=4, MODULUS=16, up from 15 -> q=0 with no X values; with UPDOWN_COUNTER_SAT_EN defined -> q stays 15 and wrap stays 0.
- Cascade: two instances of WIDTH=4, MODULUS=10, stage-1 en = stage-0 tc -> counts 00..99 in BCD order; after 100 clocks stage-1 shows 0 and has wrapped once.
